// File: rtl/ofs_plat_prim_burstcount0_packetizer_if.sv
// Handshake bundle for the burstcount0 packetizer: unframed input flit stream
// and framed output burst stream (origin-0 burstcount, explicit SOP/EOP).
interface ofs_plat_prim_burstcount0_packetizer_if #(
  parameter int BURST_CNT_WIDTH = 3,
  parameter int DATA_WIDTH      = 64
);
  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_WIDTH-1:0]      in_data;
  logic                       in_eop;

  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_WIDTH-1:0]      out_data;
  logic [BURST_CNT_WIDTH-1:0] out_burstcount;
  logic                       out_sop;
  logic                       out_eop;

  // Environment side: produces input flits, consumes output bursts.
  modport master (
    output in_valid, in_data, in_eop, out_ready,
    input  in_ready, out_valid, out_data, out_burstcount, out_sop, out_eop
  );

  // Packetizer side.
  modport slave (
    input  in_valid, in_data, in_eop, out_ready,
    output in_ready, out_valid, out_data, out_burstcount, out_sop, out_eop
  );
endinterface

// File: rtl/ofs_plat_prim_burstcount0_packetizer.sv
// Buffers an EOP-only flit stream until each burst's length is known, then emits it
// with burstcount on SOP. Optional idle force-close: OFS_PLAT_PRIM_BURST_PACKETIZER_TIMEOUT_EN.
module ofs_plat_prim_burstcount0_packetizer #(
  parameter int BURST_CNT_WIDTH = 3,
  parameter int DATA_WIDTH      = 64,
  parameter int N_MAX_BURSTS    = 2,
  parameter int LEN_FIFO_DEPTH  = 4
) (
  input  logic clk,
  input  logic reset_n,
  ofs_plat_prim_burstcount0_packetizer_if.slave pkt
);
  localparam int MAX_BURST  = 1 << BURST_CNT_WIDTH;
  localparam int DATA_DEPTH = N_MAX_BURSTS * MAX_BURST;
  localparam int DPTR_W     = $clog2(DATA_DEPTH);
  localparam int LPTR_W     = $clog2(LEN_FIFO_DEPTH);

  typedef logic [BURST_CNT_WIDTH-1:0] cnt_t;
  typedef logic [DPTR_W-1:0]          dptr_t;
  typedef enum logic {S_IDLE, S_BURST} state_e;

  logic in_fire, out_fire;
  logic close_burst, len_pop;
  cnt_t close_len;

  // ---------------- data FIFO ----------------
  logic [DATA_WIDTH-1:0] data_mem_q [DATA_DEPTH];
  dptr_t                 data_wr_q, data_rd_q;
  logic [DPTR_W:0]       data_cnt_q;

  // ---------------- length FIFO ----------------
  cnt_t              len_mem_q [LEN_FIFO_DEPTH];
  logic [LPTR_W-1:0] len_wr_q, len_rd_q;
  logic [LPTR_W:0]   len_cnt_q;
  cnt_t              len_head;
  logic              len_has_space;

  // Data depth need not be a power of two, so pointers wrap explicitly.
  function automatic dptr_t dptr_inc(input dptr_t p);
    return (p == dptr_t'(DATA_DEPTH - 1)) ? '0 : dptr_t'(p + 1'b1);
  endfunction

  assign len_head      = len_mem_q[len_rd_q];
  assign len_has_space = len_cnt_q < (LPTR_W+1)'(LEN_FIFO_DEPTH);

  // Length-FIFO space is demanded on every flit so that any flit may close a burst.
  assign pkt.in_ready = reset_n && (data_cnt_q < (DPTR_W+1)'(DATA_DEPTH)) && len_has_space;
  assign in_fire      = pkt.in_valid && pkt.in_ready;
  assign out_fire     = pkt.out_valid && pkt.out_ready;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_wr_q  <= '0;
      data_rd_q  <= '0;
      data_cnt_q <= '0;
    end else begin
      if (in_fire)  data_wr_q <= dptr_inc(data_wr_q);
      if (out_fire) data_rd_q <= dptr_inc(data_rd_q);
      case ({in_fire, out_fire})
        2'b10:   data_cnt_q <= data_cnt_q + 1'b1;
        2'b01:   data_cnt_q <= data_cnt_q - 1'b1;
        default: data_cnt_q <= data_cnt_q;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; pointers and counts alone define validity.
  always_ff @(posedge clk) begin
    if (in_fire) data_mem_q[data_wr_q] <= pkt.in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      len_wr_q  <= '0;
      len_rd_q  <= '0;
      len_cnt_q <= '0;
    end else begin
      if (close_burst) len_wr_q <= len_wr_q + 1'b1;
      if (len_pop)     len_rd_q <= len_rd_q + 1'b1;
      case ({close_burst, len_pop})
        2'b10:   len_cnt_q <= len_cnt_q + 1'b1;
        2'b01:   len_cnt_q <= len_cnt_q - 1'b1;
        default: len_cnt_q <= len_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (close_burst) len_mem_q[len_wr_q] <= close_len;
  end

  // ---------------- open-burst tracking ----------------
  logic [BURST_CNT_WIDTH:0] open_cnt_q, open_cnt_d;

`ifdef OFS_PLAT_PRIM_BURST_PACKETIZER_TIMEOUT_EN
  logic [3:0]               idle_cnt_q, idle_cnt_d;
  logic                     timeout_fire;
  logic [BURST_CNT_WIDTH:0] open_cnt_m1;

  assign open_cnt_m1  = open_cnt_q - 1'b1;
  // Fires on the 16th consecutive idle cycle; waits there if the length FIFO is full.
  assign timeout_fire = !in_fire && (open_cnt_q != '0) && (idle_cnt_q == 4'd15) && len_has_space;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (in_fire || (open_cnt_q == '0) || timeout_fire) idle_cnt_d = '0;
    else if (idle_cnt_q != 4'd15)                      idle_cnt_d = idle_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) idle_cnt_q <= '0;
    else          idle_cnt_q <= idle_cnt_d;
  end
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    open_cnt_d  = open_cnt_q;
    close_burst = 1'b0;
    close_len   = open_cnt_q[BURST_CNT_WIDTH-1:0];
    if (in_fire) begin
      if (pkt.in_eop || (open_cnt_q + 1'b1 == (BURST_CNT_WIDTH+1)'(MAX_BURST))) begin
        close_burst = 1'b1;
        open_cnt_d  = '0;
      end else begin
        open_cnt_d  = open_cnt_q + 1'b1;
      end
    end
`ifdef OFS_PLAT_PRIM_BURST_PACKETIZER_TIMEOUT_EN
    else if (timeout_fire) begin
      close_burst = 1'b1;
      close_len   = open_cnt_m1[BURST_CNT_WIDTH-1:0];
      open_cnt_d  = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) open_cnt_q <= '0;
    else          open_cnt_q <= open_cnt_d;
  end

  // ---------------- output FSM ----------------
  state_e state_q, state_d;
  cnt_t   rem_q, rem_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    len_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (out_fire) begin
          rem_d = len_head;
          if (len_head == '0) len_pop = 1'b1;
          else                state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (out_fire) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == cnt_t'(1)) begin
            len_pop = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A closed burst's flits are all in the data FIFO, so BURST never waits on data.
  always_comb begin
    pkt.out_valid      = 1'b0;
    pkt.out_sop        = 1'b1;
    pkt.out_eop        = 1'b0;
    pkt.out_burstcount = '0;
    pkt.out_data       = data_mem_q[data_rd_q];
    if (reset_n) begin
      case (state_q)
        S_IDLE: begin
          pkt.out_valid      = (len_cnt_q != '0);
          pkt.out_burstcount = len_head;
          pkt.out_eop        = (len_head == '0);
        end
        S_BURST: begin
          pkt.out_valid      = 1'b1;
          pkt.out_sop        = 1'b0;
          pkt.out_burstcount = len_head;
          pkt.out_eop        = (rem_q == cnt_t'(1));
        end
        default: pkt.out_valid = 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_ofs_plat_prim_burstcount0_packetizer.sv
// Self-checking bench: directed table, multi-cycle corner sequences, and a random
// run against a queue-based model of packet-to-burst framing.
module tb_ofs_plat_prim_burstcount0_packetizer;
  localparam int BCW    = 3;
  localparam int DW     = 64;
  localparam int MAXB   = 8;
  localparam int DDEPTH = 16;
  localparam int LDEPTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ofs_plat_prim_burstcount0_packetizer_if #(.BURST_CNT_WIDTH(BCW), .DATA_WIDTH(DW)) pkt();

  ofs_plat_prim_burstcount0_packetizer #(
    .BURST_CNT_WIDTH(BCW), .DATA_WIDTH(DW), .N_MAX_BURSTS(2), .LEN_FIFO_DEPTH(LDEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pkt(pkt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  bc;
  } flit_t;

  flit_t       exp_q[$];
  logic [63:0] open_q[$];
  int          idle = 0;

  // Sampled DUT outputs and bookkeeping.
  logic        s_in_ready, s_out_valid, s_sop, s_eop;
  logic [2:0]  s_bc;
  logic [63:0] s_data;
  logic        last_acc = 1'b0;
  int          cyc = 0;
  int          accepted = 0;
  int          out_beats = 0;
  int          first_valid_cyc = -1;
  logic [2:0]  sop_bcs[$];

  function automatic int bursts_pending();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].eop) n++;
    return n;
  endfunction

  task automatic close_open();
    int n = open_q.size();
    for (int i = 0; i < n; i++) begin
      flit_t f;
      f.data = open_q[i];
      f.sop  = (i == 0);
      f.eop  = (i == n - 1);
      f.bc   = 3'(n - 1);
      exp_q.push_back(f);
    end
    open_q.delete();
  endtask

  // One clock: drive at negedge, sample 1 time unit later, check, advance model.
  task automatic cycle(input logic v, input logic [63:0] d, input logic e,
                       input logic ordy, input logic rst_n_in);
    int nb, occ;
    @(negedge clk);
    reset_n        = rst_n_in;
    pkt.in_valid   = v;
    pkt.in_data    = d;
    pkt.in_eop     = e;
    pkt.out_ready  = ordy;
    #1;
    s_in_ready  = pkt.in_ready;
    s_out_valid = pkt.out_valid;
    s_sop       = pkt.out_sop;
    s_eop       = pkt.out_eop;
    s_bc        = pkt.out_burstcount;
    s_data      = pkt.out_data;
    last_acc    = 1'b0;
    if (!rst_n_in) begin
      check("reset in_ready", 64'(s_in_ready), 64'(0));
      check("reset out_valid", 64'(s_out_valid), 64'(0));
      check("reset out_sop", 64'(s_sop), 64'(1));
      check("reset out_eop", 64'(s_eop), 64'(0));
      check("reset out_burstcount", 64'(s_bc), 64'(0));
      exp_q.delete();
      open_q.delete();
      idle = 0;
    end else begin
      nb  = bursts_pending();
      occ = open_q.size() + exp_q.size();
      check("model in_ready", 64'(s_in_ready), 64'(occ < DDEPTH && nb < LDEPTH));
      check("model out_valid", 64'(s_out_valid), 64'(exp_q.size() != 0));
      if (s_out_valid && exp_q.size() != 0) begin
        check("model out_data", s_data, exp_q[0].data);
        check("model out_sop", 64'(s_sop), 64'(exp_q[0].sop));
        check("model out_eop", 64'(s_eop), 64'(exp_q[0].eop));
        if (exp_q[0].sop) check("model out_burstcount", 64'(s_bc), 64'(exp_q[0].bc));
      end
      if (s_out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (s_out_valid && ordy) begin
        out_beats++;
        if (s_sop) sop_bcs.push_back(s_bc);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (v && s_in_ready) begin
        last_acc = 1'b1;
        accepted++;
        open_q.push_back(d);
        idle = 0;
        if (e || open_q.size() == MAXB) close_open();
      end
`ifdef OFS_PLAT_PRIM_BURST_PACKETIZER_TIMEOUT_EN
      else if (open_q.size() != 0) begin
        if (idle < 16) idle++;
        if (idle == 16 && nb < LDEPTH) begin
          close_open();
          idle = 0;
        end
      end
`endif
    end
    cyc++;
  endtask

  task automatic send_flit(input logic [63:0] d, input logic e, input logic ordy);
    logic done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      cycle(1'b1, d, e, ordy, 1'b1);
      done = last_acc;
    end
    check("send_flit accepted", 64'(done), 64'(1));
  endtask

  task automatic idle_cycles(input int n, input logic ordy);
    for (int k = 0; k < n; k++) cycle(1'b0, 64'h0, 1'b0, ordy, 1'b1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        e;
    logic        ordy;
    logic        x_valid;
    logic        x_sop;
    logic        x_eop;
    logic [2:0]  x_bc;
    logic [63:0] x_data;
    logic        x_in_ready;
  } vec_t;

  vec_t vecs[10];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int c_acc8, c_last, beats0, acc0;
    logic [2:0] exp_bcs[3];
    logic       no_timeout_seen;

    pkt.in_valid = 1'b0; pkt.in_data = '0; pkt.in_eop = 1'b0; pkt.out_ready = 1'b0;

    //         v     d          e     ordy  valid sop   eop   bc    data       in_ready
    vecs[0] = '{1'b0, 64'h0,    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0,    1'b1};
    vecs[1] = '{1'b1, 64'hA5,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0,    1'b1};
    vecs[2] = '{1'b0, 64'h0,    1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 64'hA5,   1'b1};
    vecs[3] = '{1'b1, 64'h11,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0,    1'b1};
    vecs[4] = '{1'b1, 64'h22,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0,    1'b1};
    vecs[5] = '{1'b1, 64'h33,   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0,    1'b1};
    vecs[6] = '{1'b0, 64'h0,    1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 64'h11,   1'b1};
    vecs[7] = '{1'b0, 64'h0,    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 64'h22,   1'b1};
    vecs[8] = '{1'b0, 64'h0,    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 64'h33,   1'b1};
    vecs[9] = '{1'b0, 64'h0,    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0,    1'b1};

    // Reset state.
    cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

    // Single-flit and 3-flit packets from the table.
    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].v, vecs[i].d, vecs[i].e, vecs[i].ordy, 1'b1);
      check($sformatf("vec%0d out_valid", i), 64'(s_out_valid), 64'(vecs[i].x_valid));
      check($sformatf("vec%0d in_ready", i), 64'(s_in_ready), 64'(vecs[i].x_in_ready));
      if (vecs[i].x_valid) begin
        check($sformatf("vec%0d out_sop", i), 64'(s_sop), 64'(vecs[i].x_sop));
        check($sformatf("vec%0d out_eop", i), 64'(s_eop), 64'(vecs[i].x_eop));
        check($sformatf("vec%0d out_data", i), s_data, vecs[i].x_data);
        if (vecs[i].x_sop) check($sformatf("vec%0d out_burstcount", i), 64'(s_bc), 64'(vecs[i].x_bc));
      end
    end

    // 19-flit packet splits into 8+8+3; first SOP the cycle after flit 8 is accepted.
    first_valid_cyc = -1;
    sop_bcs.delete();
    c_acc8 = -100;
    for (int i = 0; i < 19; i++) begin
      send_flit(64'h100 + 64'(i), i == 18, 1'b1);
      if (i == 7) c_acc8 = cyc - 1;
    end
    idle_cycles(15, 1'b1);
    check("19flit first SOP cycle", 64'(first_valid_cyc), 64'(c_acc8 + 1));
    check("19flit burst count", 64'(sop_bcs.size()), 64'(3));
    exp_bcs = '{3'd7, 3'd7, 3'd2};
    if (sop_bcs.size() == 3)
      for (int i = 0; i < 3; i++)
        check($sformatf("19flit burstcount %0d", i), 64'(sop_bcs[i]), 64'(exp_bcs[i]));

    // Data FIFO backpressure: 8-flit packets with the output stalled.
    acc0 = accepted;
    for (int k = 0; k < 24; k++) begin
      int idx = accepted - acc0;
      cycle(1'b1, 64'h200 + 64'(idx), (idx % 8) == 7, 1'b0, 1'b1);
    end
    check("stall 8flit accepted", 64'(accepted - acc0), 64'(16));
    check("stall 8flit in_ready low", 64'(s_in_ready), 64'(0));
    beats0 = out_beats;
    idle_cycles(30, 1'b1);
    check("stall 8flit drained beats", 64'(out_beats - beats0), 64'(16));

    // Length FIFO backpressure: single-flit packets with the output stalled.
    acc0 = accepted;
    for (int k = 0; k < 10; k++) cycle(1'b1, 64'h300 + 64'(k), 1'b1, 1'b0, 1'b1);
    check("stall 1flit accepted", 64'(accepted - acc0), 64'(4));
    check("stall 1flit in_ready low", 64'(s_in_ready), 64'(0));
    beats0 = out_beats;
    idle_cycles(10, 1'b1);
    check("stall 1flit drained beats", 64'(out_beats - beats0), 64'(4));

    // Reset in the middle of a 5-beat burst; afterwards only new data appears.
    for (int i = 0; i < 5; i++) send_flit(64'h400 + 64'(i), i == 4, 1'b0);
    idle_cycles(3, 1'b1);
    cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
    idle_cycles(1, 1'b1);
    check("post-reset out_valid", 64'(s_out_valid), 64'(0));
    sop_bcs.delete();
    beats0 = out_beats;
    send_flit(64'hB0, 1'b0, 1'b1);
    send_flit(64'hB1, 1'b1, 1'b1);
    idle_cycles(6, 1'b1);
    check("post-reset burst beats", 64'(out_beats - beats0), 64'(2));
    check("post-reset burst count", 64'(sop_bcs.size()), 64'(1));
    if (sop_bcs.size() == 1) check("post-reset burstcount", 64'(sop_bcs[0]), 64'(1));

    // Open burst with no EOP, then idle.
    for (int i = 0; i < 3; i++) send_flit(64'h500 + 64'(i), 1'b0, 1'b1);
    c_last = cyc - 1;
    first_valid_cyc = -1;
    idle_cycles(30, 1'b1);
`ifdef OFS_PLAT_PRIM_BURST_PACKETIZER_TIMEOUT_EN
    check("timeout SOP latency", 64'(first_valid_cyc - c_last), 64'(17));
`else
    no_timeout_seen = (first_valid_cyc < 0);
    check("no timeout burst", 64'(no_timeout_seen), 64'(1));
`endif
    cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic        v    = ($urandom % 4) != 0;
      logic [63:0] d    = {$urandom, $urandom};
      logic        e    = ($urandom % 5) == 0;
      logic        ordy = ($urandom % 3) != 0;
      cycle(v, d, e, ordy, 1'b1);
    end
    idle_cycles(60, 1'b1);
    check("random drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
